// File: rtl/load_store_unit.sv
// load_store_unit: RV32I data-memory access stage. Accepts one load/store at a
// time, checks legality and alignment, runs a single word-aligned valid/ack
// memory transaction and returns the extracted, extended load value or a
// store completion. Rejected accesses answer directly without touching memory.
module load_store_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_store,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_data,
   output logic [1:0]      resp_err,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [3:0]      mem_be,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b10;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;

   state_t            state_q, state_d;
   logic              resp_valid_q, resp_valid_d;
   logic [XLEN-1:0]   resp_data_q, resp_data_d;
   logic [1:0]        resp_err_q, resp_err_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
   // Access shape remembered at accept for extracting the load result later.
   logic [1:0]        offset_q, offset_d;
   logic [1:0]        size_q, size_d;
   logic              unsigned_q, unsigned_d;
   logic              store_q, store_d;

   logic              accept;
   logic [1:0]        req_size;
   logic              req_illegal;
   logic              req_misaligned;
   logic [3:0]        req_be;
   logic [XLEN-1:0]   req_wdata_placed;
   logic [XLEN-1:0]   rdata_shifted;
   logic [XLEN-1:0]   load_value;

   assign req_ready  = (state_q == IDLE) && !rst;
   assign accept     = req_valid && req_ready;
   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_err   = resp_err_q;
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_be     = mem_be_q;
   assign mem_wdata  = mem_wdata_q;

   // Decode the incoming request: legality, alignment, lane enables, store data.
   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      req_size         = req_funct3[1:0];
      req_illegal      = 1'b0;
      req_misaligned   = 1'b0;
      req_be           = 4'b1111;
      req_wdata_placed = req_wdata;

      if (req_store) req_illegal = (req_funct3 > 3'b010);
      else           req_illegal = (req_funct3[1:0] == 2'b11) ||
                                   (req_funct3 == 3'b110);

      case (req_size)
         SZ_BYTE: begin
            req_be           = 4'b0001 << req_addr[1:0];
            req_wdata_placed = {4{req_wdata[7:0]}};
         end
         SZ_HALF: begin
            req_misaligned   = req_addr[0];
            req_be           = req_addr[1] ? 4'b1100 : 4'b0011;
            req_wdata_placed = {2{req_wdata[15:0]}};
         end
         default: begin
            req_misaligned   = (req_addr[1:0] != 2'b00);
         end
      endcase
   end

   // Extract the addressed lane from the read word and sign/zero-extend it.
   always_comb begin
      rdata_shifted = mem_rdata >> {offset_q, 3'b000};
      case (size_q)
         SZ_BYTE: load_value = {{(XLEN-8){!unsigned_q && rdata_shifted[7]}},
                                rdata_shifted[7:0]};
         SZ_HALF: load_value = {{(XLEN-16){!unsigned_q && rdata_shifted[15]}},
                                rdata_shifted[15:0]};
         default: load_value = rdata_shifted;
      endcase
   end

   // Next-state and registered-output logic of the IDLE/MEM/RESP controller.
   always_comb begin
      state_d      = state_q;
      resp_valid_d = 1'b0;
      resp_data_d  = resp_data_q;
      resp_err_d   = resp_err_q;
      mem_req_d    = 1'b0;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_be_d     = mem_be_q;
      mem_wdata_d  = mem_wdata_q;
      offset_d     = offset_q;
      size_d       = size_q;
      unsigned_d   = unsigned_q;
      store_d      = store_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               offset_d   = req_addr[1:0];
               size_d     = req_size;
               unsigned_d = req_funct3[2];
               store_d    = req_store;
               if (req_illegal || req_misaligned) begin
                  // Rejected: answer next cycle, memory is never requested.
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_data_d  = '0;
                  resp_err_d   = req_illegal ? ERR_ILLEGAL : ERR_MISALIGN;
               end else begin
                  state_d     = MEM;
                  mem_req_d   = 1'b1;
                  mem_we_d    = req_store;
                  mem_addr_d  = {req_addr[XLEN-1:2], 2'b00};
                  mem_be_d    = req_be;
                  mem_wdata_d = req_wdata_placed;
               end
            end
         end
         MEM: begin
            mem_req_d = 1'b1;
            if (mem_ack) begin
               state_d      = RESP;
               mem_req_d    = 1'b0;
               resp_valid_d = 1'b1;
               resp_err_d   = ERR_OK;
               resp_data_d  = store_q ? '0 : load_value;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register with synchronous reset that also aborts any pending access.
   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_err_q   <= ERR_OK;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_be_q     <= 4'b0000;
         mem_wdata_q  <= '0;
         offset_q     <= 2'b00;
         size_q       <= 2'b00;
         unsigned_q   <= 1'b0;
         store_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_err_q   <= resp_err_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_be_q     <= mem_be_d;
         mem_wdata_q  <= mem_wdata_d;
         offset_q     <= offset_d;
         size_q       <= size_d;
         unsigned_q   <= unsigned_d;
         store_q      <= store_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table, hand-written multi-cycle
// sequences (reset abort, back-to-back) and randomized accesses checked
// against a byte-level reference model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic [1:0]  resp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int checks   = 0;
   int failures = 0;

   load_store_unit #(.XLEN(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_store  (req_store),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_err   (resp_err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        store;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          dly;
      logic [1:0]  e_err;
      logic [3:0]  e_be;
      logic [31:0] e_wdata;
      logic [31:0] e_data;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Advance one clock; everything is driven and sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: per-byte view of the access, derived from the ISA rules.
   task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd,
                        output logic [1:0] err, output logic [3:0] be,
                        output logic [31:0] wdata, output logic [31:0] data);
      int     nb;
      int     off;
      longint v;
      logic   legal;
      nb  = 1 << f3[1:0];
      off = int'(addr[1:0]);
      if (st) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
                      (f3 == 3'd4) || (f3 == 3'd5);
      err = 2'b00; be = 4'b0000; wdata = 32'd0; data = 32'd0;
      if (!legal)              err = 2'b10;
      else if (off % nb != 0)  err = 2'b01;
      else begin
         for (int k = 0; k < nb; k++) be[off + k] = 1'b1;
         for (int lane = 0; lane < 4; lane++)
            wdata[8*lane +: 8] = wd[8*(lane % nb) +: 8];
         if (!st) begin
            v = 0;
            for (int k = 0; k < nb; k++)
               v = v | (longint'(rd[8*(off + k) +: 8]) << (8*k));
            if (!f3[2] && nb < 4 && v[8*nb-1]) v = v - (longint'(1) << (8*nb));
            data = v[31:0];
         end
      end
   endtask

   // Drive one access through the handshake and compare every observable step.
   task automatic run_access(input string tag, input logic st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rd, input int dly,
                             input logic [1:0] e_err, input logic [3:0] e_be,
                             input logic [31:0] e_wdata, input logic [31:0] e_data);
      int n = 0;
      req_valid = 1'b1; req_store = st; req_funct3 = f3;
      req_addr = addr; req_wdata = wd;
      while (!req_ready && n < 10) begin step(); n++; end
      check({tag, " req_ready"}, 32'(req_ready), 32'd1);
      step();
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
      if (e_err != 2'b00) begin
         check({tag, " err resp_valid"}, 32'(resp_valid), 32'd1);
         check({tag, " err no mem_req"}, 32'(mem_req), 32'd0);
         check({tag, " resp_err"}, 32'(resp_err), 32'(e_err));
         check({tag, " err resp_data"}, resp_data, 32'd0);
      end else begin
         check({tag, " mem_req"}, 32'(mem_req), 32'd1);
         check({tag, " mem_addr"}, mem_addr, {addr[31:2], 2'b00});
         check({tag, " mem_be"}, 32'(mem_be), 32'(e_be));
         check({tag, " mem_we"}, 32'(mem_we), 32'(st));
         if (st) check({tag, " mem_wdata"}, mem_wdata, e_wdata);
         for (int i = 0; i < dly; i++) begin
            check({tag, " early resp_valid"}, 32'(resp_valid), 32'd0);
            step();
         end
         check({tag, " mem_req held"}, 32'(mem_req), 32'd1);
         check({tag, " mem_addr held"}, mem_addr, {addr[31:2], 2'b00});
         mem_ack = 1'b1; mem_rdata = rd;
         step();
         mem_ack = 1'b0; mem_rdata = $urandom;
         check({tag, " resp_valid"}, 32'(resp_valid), 32'd1);
         check({tag, " mem_req drop"}, 32'(mem_req), 32'd0);
         check({tag, " resp_err ok"}, 32'(resp_err), 32'd0);
         check({tag, " resp_data"}, resp_data, e_data);
      end
      step();
      check({tag, " resp_valid pulse"}, 32'(resp_valid), 32'd0);
      check({tag, " ready again"}, 32'(req_ready), 32'd1);
   endtask

   vec_t        vecs [12];
   logic [31:0] words [4];
   int          acc_cyc [3];

   initial begin
      logic        r_st;
      logic [2:0]  r_f3;
      logic [31:0] r_addr, r_wd, r_rd;
      logic [1:0]  m_err;
      logic [3:0]  m_be;
      logic [31:0] m_wd, m_data;
      int          n_acc, n_resp;

      vecs[0]  = '{"SW 0x100",   1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0,        2, 2'b00, 4'b1111, 32'hDEADBEEF, 32'h0};
      vecs[1]  = '{"LB 0x103",   1'b0, 3'd0, 32'h103, 32'h0,        32'h80112233, 0, 2'b00, 4'b1000, 32'h0,        32'hFFFFFF80};
      vecs[2]  = '{"LBU 0x103",  1'b0, 3'd4, 32'h103, 32'h0,        32'h80112233, 0, 2'b00, 4'b1000, 32'h0,        32'h00000080};
      vecs[3]  = '{"LH 0x102",   1'b0, 3'd1, 32'h102, 32'h0,        32'h80011234, 1, 2'b00, 4'b1100, 32'h0,        32'hFFFF8001};
      vecs[4]  = '{"LHU 0x102",  1'b0, 3'd5, 32'h102, 32'h0,        32'h80011234, 0, 2'b00, 4'b1100, 32'h0,        32'h00008001};
      vecs[5]  = '{"SB 0x101",   1'b1, 3'd0, 32'h101, 32'h000000AB, 32'h0,        0, 2'b00, 4'b0010, 32'hABABABAB, 32'h0};
      vecs[6]  = '{"SH 0x101",   1'b1, 3'd1, 32'h101, 32'h0,        32'h0,        0, 2'b01, 4'b0000, 32'h0,        32'h0};
      vecs[7]  = '{"LW 0x102",   1'b0, 3'd2, 32'h102, 32'h0,        32'h0,        0, 2'b01, 4'b0000, 32'h0,        32'h0};
      vecs[8]  = '{"L011 0x101", 1'b0, 3'd3, 32'h101, 32'h0,        32'h0,        0, 2'b10, 4'b0000, 32'h0,        32'h0};
      vecs[9]  = '{"LW 0x200",   1'b0, 3'd2, 32'h200, 32'h0,        32'h12345678, 1, 2'b00, 4'b1111, 32'h0,        32'h12345678};
      vecs[10] = '{"SH 0x102",   1'b1, 3'd1, 32'h102, 32'h0000CAFE, 32'h0,        3, 2'b00, 4'b1100, 32'hCAFECAFE, 32'h0};
      vecs[11] = '{"S100 0x0",   1'b1, 3'd4, 32'h0,   32'h0,        32'h0,        0, 2'b10, 4'b0000, 32'h0,        32'h0};

      rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
      step(); step(); step();

      // Reset state.
      check("reset req_ready", 32'(req_ready), 32'd0);
      check("reset mem_req", 32'(mem_req), 32'd0);
      check("reset mem_we", 32'(mem_we), 32'd0);
      check("reset resp_valid", 32'(resp_valid), 32'd0);
      check("reset mem_addr", mem_addr, 32'd0);
      check("reset mem_be", 32'(mem_be), 32'd0);
      check("reset mem_wdata", mem_wdata, 32'd0);
      check("reset resp_data", resp_data, 32'd0);
      check("reset resp_err", 32'(resp_err), 32'd0);
      rst = 1'b0;
      #1;
      check("post-reset req_ready", 32'(req_ready), 32'd1);

      // Directed vector table.
      foreach (vecs[i])
         run_access(vecs[i].name, vecs[i].store, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                    vecs[i].rdata, vecs[i].dly, vecs[i].e_err, vecs[i].e_be,
                    vecs[i].e_wdata, vecs[i].e_data);

      // Reset while waiting for memory: access is dropped, late ack ignored.
      req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h40;
      step();
      req_valid = 1'b0;
      check("abort mem_req before rst", 32'(mem_req), 32'd1);
      rst = 1'b1;
      step();
      check("abort mem_req", 32'(mem_req), 32'd0);
      check("abort ready in rst", 32'(req_ready), 32'd0);
      rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
      #1;
      check("abort ready after rst", 32'(req_ready), 32'd1);
      step();
      check("abort late ack no resp", 32'(resp_valid), 32'd0);
      mem_ack = 1'b0;
      step();
      check("abort no resp later", 32'(resp_valid), 32'd0);

      // Back-to-back LWs with req_valid held and immediate ack.
      words[0] = 32'h11111111; words[1] = 32'h22222222;
      words[2] = 32'h33333333; words[3] = 32'hBAD0BAD0;
      n_acc = 0; n_resp = 0;
      for (int cyc = 0; cyc < 16; cyc++) begin
         mem_ack   = mem_req;
         mem_rdata = words[mem_addr[3:2]];
         if (resp_valid) begin
            if (n_resp < 3) check("b2b resp_data", resp_data, words[n_resp]);
            else            check("b2b extra resp", 32'd1, 32'd0);
            n_resp++;
         end
         req_valid = (n_acc < 3); req_store = 1'b0; req_funct3 = 3'd2;
         req_addr  = 32'(n_acc * 4);
         if (req_valid && req_ready) begin
            acc_cyc[n_acc] = cyc;
            n_acc++;
         end
         step();
      end
      req_valid = 1'b0; mem_ack = 1'b0;
      check("b2b accepts", 32'(n_acc), 32'd3);
      check("b2b responses", 32'(n_resp), 32'd3);
      check("b2b spacing 0-1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
      check("b2b spacing 1-2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);

      // Randomized accesses against the reference model.
      for (int t = 0; t < 60; t++) begin
         r_st   = 1'($urandom_range(0, 1));
         r_f3   = 3'($urandom_range(0, 7));
         r_addr = $urandom;
         r_wd   = $urandom;
         r_rd   = $urandom;
         model(r_st, r_f3, r_addr, r_wd, r_rd, m_err, m_be, m_wd, m_data);
         run_access($sformatf("rand%0d", t), r_st, r_f3, r_addr, r_wd, r_rd,
                    $urandom_range(0, 3), m_err, m_be, m_wd, m_data);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage of the RV32I core, directly downstream of `alu`: it takes the effective address that the ALU computes for loads and stores (`rs1 + imm`), together with `funct3` and store data. It performs one word-aligned memory transaction through a valid/ack handshake and returns the extracted, sign- or zero-extended load value, or a store completion. Misaligned and illegal-width accesses are rejected without touching memory.

## Interface
- `XLEN`, 32 — data/address width; comes from `riscv.h`; only 32 is supported.
- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst` input 1 — reset, synchronous, active-high.
- `req_valid` input 1 — core presents an access.
- `req_ready` output 1 — unit accepts a request; equals `state==IDLE && !rst`.
- `req_store` input 1 — 1 = store, 0 = load.
- `req_funct3` input 3 — RV32I width/sign field.
- `req_addr` input XLEN — effective address (ALU `out`).
- `req_wdata` input XLEN — store data (`rs2`).
- `resp_valid` output 1 — one-cycle completion pulse.
- `resp_data` output XLEN — load result; 0 for stores and errors.
- `resp_err` output 2 — 00 ok, 01 misaligned, 10 illegal `funct3`.
- `mem_req` output 1 — memory transaction pending.
- `mem_we` output 1 — write enable.
- `mem_addr` output XLEN — `{req_addr[XLEN-1:2], 2'b00}`.
- `mem_be` output 4 — byte enables.
- `mem_wdata` output XLEN — lane-replicated store data.
- `mem_ack` input 1 — memory completes the transaction; `mem_rdata` is valid in the same cycle.
- `mem_rdata` input XLEN — read word.

## Operation
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW. Any other load or store `funct3` is illegal.
- Checks at accept; illegal takes precedence over misaligned:
  - Half accesses are misaligned when `addr[0]` is 1.
  - Word accesses are misaligned when `addr[1:0]` is not 0.
- Byte enables:
  - Byte: `4'b0001 << addr[1:0]`.
  - Half: `0011` when `addr[1]` is 0, otherwise `1100`.
  - Word: `1111`.
  - The same pattern is driven for loads, with `mem_we=0`.
- Store data placement:
  - SB replicates `wdata[7:0]` to all four lanes.
  - SH replicates `wdata[15:0]` to both halves.
  - SW passes `wdata` through unchanged.
- Load extraction: shift `mem_rdata` right by `8*addr[1:0]`, keep 8, 16 or 32 bits, then sign-extend (LB/LH) or zero-extend (LBU/LHU). The offset, width and sign are latched at accept.
- FSM states: IDLE, MEM, RESP.
  - IDLE→MEM on accept when the access is legal and aligned.
  - IDLE→RESP on accept when the access is illegal or misaligned. The error code is latched and `mem_req` never asserts.
  - MEM→RESP on `mem_ack`; `mem_rdata` is captured.
  - RESP→IDLE unconditionally.
- All `mem_*` outputs are registered at accept and held stable while `mem_req` is high.

## Timing
- Reset values: `mem_req`, `mem_we`, `resp_valid` = 0; `mem_addr`, `mem_wdata`, `resp_data` = 0; `mem_be` = 0000; `resp_err` = 00; state IDLE. `req_ready` is 0 while `rst` is high.
- Accept occurs in cycle T when `req_valid && req_ready`.
- `mem_req` is high from T+1 until and including the cycle in which `mem_ack` is sampled high. The earliest ack is at T+1. A `mem_ack` with `mem_req` low is ignored.
- `resp_valid` is high for exactly one cycle, at (ack cycle)+1. The minimum load/store latency is therefore 2 cycles.
- Error path: `resp_valid` at T+1 with no `mem_req`.
- `req_ready` is low in MEM and RESP. The next accept is earliest in the cycle after `resp_valid`, giving a maximum throughput of one access per 3 cycles.
- `rst` in any state: at the next edge the state returns to IDLE and `mem_req` and `resp_valid` drop to 0. No response is produced for the aborted access, and a late `mem_ack` is ignored.
- `resp_data` and `resp_err` are valid only while `resp_valid` is high. They keep their value until the next response.

## Test plan
- SW, addr 0x100, wdata 0xDEADBEEF, ack 2 cycles after `mem_req` rises → `mem_addr`=0x100, `mem_be`=1111, `mem_we`=1, `mem_wdata`=0xDEADBEEF; `resp_valid` the cycle after ack with err 00 and data 0.
- LB/LBU, addr 0x103, `mem_rdata` 0x80112233, ack at T+1 → `mem_be`=1000; LB gives 0xFFFFFF80, LBU gives 0x00000080; `resp_valid` at T+2.
- LH/LHU, addr 0x102, `mem_rdata` 0x80011234 → `mem_be`=1100; LH gives 0xFFFF8001, LHU gives 0x00008001. SB, addr 0x101, wdata 0x000000AB → `mem_wdata`=0xABABABAB, `mem_be`=0010.
- SH at 0x101 → no `mem_req`, `resp_err`=01 at T+1. LW at 0x102 → `resp_err`=01. Load with `funct3`=011 at 0x101 → `resp_err`=10 (illegal wins).
- LW issued, `rst` asserted while in MEM → `mem_req`=0 the next cycle; a subsequent `mem_ack` produces no `resp_valid`; `req_ready`=1 after `rst` drops.
- Back-to-back `req_valid` held high for three LWs (0x0, 0x4, 0x8) with immediate ack → accepts spaced exactly 3 cycles apart, and results match `mem_rdata` in order.
